gf_op_sequencer: RTL
====================

Name: gf_op_sequencer

Overview:
- Command front-end that sits directly upstream of the `cl_modules` carry-less datapath and drives its control and operand inputs.
- Accepts one GF / integer operation per valid/ready request and runs the datapath through one or two phases: multiply, then reduction for mul-reduce.
- Captures the datapath results and returns them on a valid/ready response port.
- Owns the `op_enable` pulse discipline and a hang watchdog, so software-side logic never touches the datapath directly.

Parameters:
- DATA_WIDTH, 32, operand width; must equal the attached datapath's DATA_WIDTH.
- WD_CYCLES, 2*DATA_WIDTH+16, watchdog limit in cycles per datapath phase.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_op  in  2  operation: 0 add, 1 carry-less multiply, 2 square, 3 multiply-then-reduce.
- req_carry  in  1  carry option for add (1 = carry, 0 = XOR).
- req_width  in  $clog2(DATA_WIDTH)+1  field degree m.
- req_poly  in  DATA_WIDTH+1  primitive polynomial.
- req_a, req_b  in  DATA_WIDTH each  operands.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response ready.
- resp_data  out  2*DATA_WIDTH  result.
- resp_carry  out  1  carry out (add only, else 0).
- resp_err  out  1  1 = illegal width or watchdog abort.
- dp_op_enable, dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option  out  1 each  datapath controls.
- dp_in_width  out  $clog2(DATA_WIDTH)+1  datapath width.
- dp_polyn_red  out  DATA_WIDTH+1  datapath polynomial.
- dp_reduc_in  out  2*DATA_WIDTH  datapath polynomial to reduce.
- dp_in_a, dp_in_b  out  DATA_WIDTH each  datapath operands.
- dp_op_finish  in  1  datapath done.
- dp_out  in  DATA_WIDTH  datapath add result.
- dp_out_poly  in  DATA_WIDTH  datapath reduction result.
- dp_out_mult  in  2*DATA_WIDTH  datapath multiply result.
- dp_out_carry  in  1  datapath carry out.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs 0 except req_ready = 1.
  - Latched operands cleared; watchdog cleared.
  - dp_op_enable drops immediately; the datapath self-clears while enable is low.
- States: IDLE, RUN1, GAP, RUN2, RESP.
- IDLE:
  - Accept when req_valid && req_ready. Latch all req_* fields; req_ready falls the next cycle.
  - If req_op != 0 and (req_width < 2 or req_width > DATA_WIDTH): go to RESP with resp_err = 1 and resp_data = 0; the datapath is never enabled.
  - Otherwise go to RUN1.
- RUN1:
  - dp_op_enable = 1 and all dp_* operand/control outputs held stable from the latched fields.
  - dp_sum_funct = (op == 0); dp_exp_funct = (op == 2); dp_red_funct = 0; dp_carry_option = carry for op 0, else 0.
  - On the first cycle dp_op_finish is sampled high, capture results:
    - op 0: resp_data = zero-extended dp_out, resp_carry = dp_out_carry.
    - op 1/2: resp_data = dp_out_mult.
    - op 3: store dp_out_mult internally, then go to GAP.
  - Ops 0–2 go to RESP.
- GAP:
  - Exactly 1 cycle with dp_op_enable = 0, so the datapath counters and finish flag clear.
  - dp_reduc_in is loaded with the stored product, dp_red_funct = 1.
  - Go to RUN2.
- RUN2:
  - dp_op_enable = 1, dp_red_funct = 1.
  - When dp_op_finish is sampled high: resp_data = zero-extended dp_out_poly, then go to RESP.
- RESP:
  - dp_op_enable = 0, resp_valid = 1; data, carry and err are held stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid falls, state returns to IDLE, and req_ready rises the next cycle.
  - At least one cycle with enable low therefore separates consecutive requests.
- Watchdog:
  - Counts cycles in RUN1/RUN2 and restarts on each phase entry.
  - On reaching WD_CYCLES with no finish: go to RESP with resp_err = 1 and resp_data = 0.
- Simultaneous events:
  - A request arriving while not IDLE is not accepted.
  - dp_op_finish seen during IDLE, GAP or RESP is ignored.
  - A response backpressured indefinitely holds all dp_* outputs at the idle value (enable 0).
- Throughput: one op in flight.
- Latency, accept to resp_valid: op 0 is 3 cycles. Other ops are the datapath finish time plus 2 per phase, plus 1 for GAP.

Test Plan:
- (1) Mul-reduce: width 8, poly 0x11B, a = 0x53, b = 0xCA, op 3 -> resp_data = 0x01, err 0. The bench must also check that RUN1 captured 0x3F7E internally and that GAP holds dp_op_enable low for exactly 1 cycle.
- (2) Carry-less multiply: op 1, width 8, a = 0x53, b = 0xCA -> resp_data[15:0] = 0x3F7E. Square: op 2, a = 0x53 -> resp_data[15:0] = 0x1105.
- (3) Add:
  - op 0, carry = 1, a = 0xFFFFFFFF, b = 1 -> resp_data 0, resp_carry 1.
  - carry = 0, a = 0x53, b = 0xCA -> resp_data 0x99, resp_carry 0.
- (4) Illegal width: op 1, width 1 -> resp_err 1, resp_data 0, dp_op_enable never asserted. Repeat with width DATA_WIDTH+1.
- (5) Backpressure and back-to-back requests:
  - Hold resp_ready = 0 for 10 cycles -> response stable and req_ready = 0 throughout.
  - A second request queued on req_valid is accepted only after the handshake and completes correctly.
- (6) Watchdog and reset:
  - Stub the datapath so dp_op_finish is never asserted -> resp_err after exactly WD_CYCLES in RUN1.
  - Assert rst mid-RUN2 -> immediate IDLE with outputs at reset values; the next op 3 request returns the correct result.

Source files
------------

// File: rtl/gf_op_sequencer.sv
// gf_op_sequencer: command front-end for the carry-less datapath.
// Takes one add / clmul / square / mul-reduce request at a time, runs the
// datapath through one or two enable phases, and returns the captured result
// on a valid/ready response port. A per-phase watchdog aborts hung operations.
module gf_op_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int WD_CYCLES  = 2*DATA_WIDTH+16
) (
   input  logic                          clk,
   input  logic                          rst,
   // request port
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [1:0]                    req_op,
   input  logic                          req_carry,
   input  logic [$clog2(DATA_WIDTH):0]   req_width,
   input  logic [DATA_WIDTH:0]           req_poly,
   input  logic [DATA_WIDTH-1:0]         req_a,
   input  logic [DATA_WIDTH-1:0]         req_b,
   // response port
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [2*DATA_WIDTH-1:0]       resp_data,
   output logic                          resp_carry,
   output logic                          resp_err,
   // datapath controls and operands
   output logic                          dp_op_enable,
   output logic                          dp_sum_funct,
   output logic                          dp_exp_funct,
   output logic                          dp_red_funct,
   output logic                          dp_carry_option,
   output logic [$clog2(DATA_WIDTH):0]   dp_in_width,
   output logic [DATA_WIDTH:0]           dp_polyn_red,
   output logic [2*DATA_WIDTH-1:0]       dp_reduc_in,
   output logic [DATA_WIDTH-1:0]         dp_in_a,
   output logic [DATA_WIDTH-1:0]         dp_in_b,
   // datapath results
   input  logic                          dp_op_finish,
   input  logic [DATA_WIDTH-1:0]         dp_out,
   input  logic [DATA_WIDTH-1:0]         dp_out_poly,
   input  logic [2*DATA_WIDTH-1:0]       dp_out_mult,
   input  logic                          dp_out_carry
);

   localparam int WW = $clog2(DATA_WIDTH) + 1;
   localparam int CW = $clog2(WD_CYCLES + 1);
   localparam logic [WW-1:0] MIN_WIDTH = WW'(2);
   localparam logic [WW-1:0] MAX_WIDTH = WW'(DATA_WIDTH);
   localparam logic [CW-1:0] WD_LAST   = CW'(WD_CYCLES - 1);
   localparam logic [1:0]    OP_ADD    = 2'd0;
   localparam logic [1:0]    OP_SQR    = 2'd2;
   localparam logic [1:0]    OP_MULRED = 2'd3;

   typedef enum logic [2:0] {IDLE, RUN1, GAP, RUN2, RESP} state_t;

   state_t                  state, state_nxt;
   logic [1:0]              op_q;
   logic                    carry_q;
   logic [WW-1:0]           width_q;
   logic [DATA_WIDTH:0]     poly_q;
   logic [DATA_WIDTH-1:0]   a_q, b_q;
   logic [2*DATA_WIDTH-1:0] prod_q;
   logic [2*DATA_WIDTH-1:0] resp_data_q;
   logic                    resp_carry_q;
   logic                    resp_err_q;
   logic [CW-1:0]           wd_cnt;

   // Arithmetic ops only need a legal field degree; add ignores width.
   logic illegal_width;
   logic wd_expire;
   assign illegal_width = (req_op != OP_ADD) &&
                          ((req_width < MIN_WIDTH) || (req_width > MAX_WIDTH));
   assign wd_expire     = (wd_cnt == WD_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of block evaluation order.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; finish wins over a watchdog expiry on the same cycle.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // state_nxt unassigned, which would infer a latch.
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = illegal_width ? RESP : RUN1;
         RUN1: begin
            if (dp_op_finish)   state_nxt = (op_q == OP_MULRED) ? GAP : RESP;
            else if (wd_expire) state_nxt = RESP;
         end
         GAP:  state_nxt = RUN2;
         RUN2: if (dp_op_finish || wd_expire) state_nxt = RESP;
         RESP: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, result capture and per-phase watchdog counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= '0;
         carry_q      <= 1'b0;
         width_q      <= '0;
         poly_q       <= '0;
         a_q          <= '0;
         b_q          <= '0;
         prod_q       <= '0;
         resp_data_q  <= '0;
         resp_carry_q <= 1'b0;
         resp_err_q   <= 1'b0;
         wd_cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               op_q         <= req_op;
               carry_q      <= req_carry;
               width_q      <= req_width;
               poly_q       <= req_poly;
               a_q          <= req_a;
               b_q          <= req_b;
               prod_q       <= '0;
               resp_data_q  <= '0;
               resp_carry_q <= 1'b0;
               resp_err_q   <= illegal_width;
               wd_cnt       <= '0;
            end
            RUN1: begin
               if (dp_op_finish) begin
                  wd_cnt <= '0;
                  case (op_q)
                     OP_ADD: begin
                        resp_data_q  <= {{DATA_WIDTH{1'b0}}, dp_out};
                        resp_carry_q <= dp_out_carry;
                     end
                     OP_MULRED: prod_q      <= dp_out_mult;
                     default:   resp_data_q <= dp_out_mult;
                  endcase
               end else if (wd_expire) begin
                  resp_err_q  <= 1'b1;
                  resp_data_q <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            GAP: wd_cnt <= '0;
            RUN2: begin
               if (dp_op_finish) begin
                  resp_data_q <= {{DATA_WIDTH{1'b0}}, dp_out_poly};
               end else if (wd_expire) begin
                  resp_err_q  <= 1'b1;
                  resp_data_q <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs by state; the datapath sees all-zero idle values outside the phases.
   always_comb begin
      req_ready       = (state == IDLE);
      resp_valid      = (state == RESP);
      resp_data       = resp_data_q;
      resp_carry      = resp_carry_q;
      resp_err        = resp_err_q;
      dp_op_enable    = 1'b0;
      dp_sum_funct    = 1'b0;
      dp_exp_funct    = 1'b0;
      dp_red_funct    = 1'b0;
      dp_carry_option = 1'b0;
      dp_in_width     = '0;
      dp_polyn_red    = '0;
      dp_reduc_in     = '0;
      dp_in_a         = '0;
      dp_in_b         = '0;
      case (state)
         RUN1: begin
            dp_op_enable    = 1'b1;
            dp_sum_funct    = (op_q == OP_ADD);
            dp_exp_funct    = (op_q == OP_SQR);
            dp_carry_option = (op_q == OP_ADD) && carry_q;
            dp_in_width     = width_q;
            dp_polyn_red    = poly_q;
            dp_in_a         = a_q;
            dp_in_b         = b_q;
         end
         GAP, RUN2: begin
            dp_op_enable = (state == RUN2);
            dp_red_funct = 1'b1;
            dp_in_width  = width_q;
            dp_polyn_red = poly_q;
            dp_reduc_in  = prod_q;
         end
         default: ;
      endcase
   end

endmodule
